sample_accumulator: RTL

Parametrised successor to the synth top-level subsample summing path: accumulates a variable-length frame of signed subsamples from the operator core into one output sample, scales by a programmable arithmetic shift, saturates to the output width and buffers finished samples in a small FIFO. It sits between the core's subsample stream and the DAC/PWM output stage. The downstream side uses a valid/ready handshake. Overrun, clip and frame-length errors are reported through sticky status flags.

---
 rtl/sample_accumulator_if.sv | 37 +++
 rtl/sample_accumulator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sample_accumulator_if.sv
// Subsample-in / sample-out bus of sample_accumulator.
//   slave  : the accumulator (takes subsamples, presents FIFO head + status)
//   master : the core/consumer side driving subsamples and i_SampleReady
interface sample_accumulator_if #(
  parameter int SUBSAMPLE_WIDTH = 16,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int FIFO_DEPTH      = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                              i_SubsampleValid;
  logic signed [SUBSAMPLE_WIDTH-1:0] i_Subsample;
  logic                              i_SubsampleLast;
  logic        [4:0]                 i_Shift;
  logic                              i_ClearFlags;
  logic                              o_SampleValid;
  logic                              i_SampleReady;
  logic signed [SAMPLE_WIDTH-1:0]    o_Sample;
  logic        [LVL_W-1:0]           o_FifoLevel;
  logic                              o_Overrun;
  logic                              o_Clipped;
  logic                              o_FrameError;

  modport slave (
    input  i_SubsampleValid, i_Subsample, i_SubsampleLast, i_Shift,
           i_ClearFlags, i_SampleReady,
    output o_SampleValid, o_Sample, o_FifoLevel, o_Overrun, o_Clipped,
           o_FrameError
  );

  modport master (
    output i_SubsampleValid, i_Subsample, i_SubsampleLast, i_Shift,
           i_ClearFlags, i_SampleReady,
    input  o_SampleValid, o_Sample, o_FifoLevel, o_Overrun, o_Clipped,
           o_FrameError
  );
endinterface

// File: rtl/sample_accumulator.sv
// Frame accumulator: sums a variable-length frame of signed subsamples,
// arithmetic-shifts and saturates the sum at frame end, and queues the
// result in a small output FIFO with a valid/ready consumer side.
// Ports:
//   i_Clock  rising-edge clock
//   i_Reset  async active-low reset
//   bus      sample_accumulator_if.slave (subsample stream, FIFO head,
//            level and sticky overrun / clip / frame-error flags)
module sample_accumulator #(
  parameter int SUBSAMPLE_WIDTH = 16,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int MAX_SUBSAMPLES  = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  sample_accumulator_if.slave   bus
);
  localparam int ACC_W = SUBSAMPLE_WIDTH + $clog2(MAX_SUBSAMPLES);
  localparam int CNT_W = $clog2(MAX_SUBSAMPLES) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] r_Acc;
  logic        [CNT_W-1:0] r_Count;

  logic signed [ACC_W-1:0] sub_ext, sum, shifted;
  logic                    at_max, frame_end, clip_hi, clip_lo;
  logic [SAMPLE_WIDTH-1:0] sat;

  assign sub_ext   = {{(ACC_W-SUBSAMPLE_WIDTH){bus.i_Subsample[SUBSAMPLE_WIDTH-1]}},
                      bus.i_Subsample};
  assign at_max    = (r_Count == CNT_W'(MAX_SUBSAMPLES));
  assign frame_end = bus.i_SubsampleValid & bus.i_SubsampleLast;
  // A full frame ignores the closing subsample; the sum is r_Acc alone.
  assign sum       = at_max ? r_Acc : r_Acc + sub_ext;
  // >>> on a signed operand sign-fills, so shifts past ACC_W give 0 / -1.
  assign shifted   = sum >>> bus.i_Shift;
  assign clip_hi   = shifted > SAT_MAX;
  assign clip_lo   = shifted < SAT_MIN;
  assign sat       = clip_hi ? SAT_MAX[SAMPLE_WIDTH-1:0] :
                     clip_lo ? SAT_MIN[SAMPLE_WIDTH-1:0] :
                               shifted[SAMPLE_WIDTH-1:0];

  // Accumulator / frame counter
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Acc   <= '0;
      r_Count <= '0;
    end else if (bus.i_SubsampleValid) begin
      if (bus.i_SubsampleLast) begin
        r_Acc   <= '0;
        r_Count <= '0;
      end else if (!at_max) begin
        r_Acc   <= r_Acc + sub_ext;
        r_Count <= r_Count + 1'b1;
      end
    end
  end

  // Output FIFO
  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        r_Level;
  logic                    full, pop, push_ok;

  assign full    = (r_Level == LVL_W'(FIFO_DEPTH));
  assign pop     = bus.o_SampleValid & bus.i_SampleReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = frame_end & (~full | pop);

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      r_Level <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= sat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   r_Level <= r_Level + 1'b1;
        2'b01:   r_Level <= r_Level - 1'b1;
        default: r_Level <= r_Level;
      endcase
    end
  end

  assign bus.o_Sample      = mem[rd_ptr];
  assign bus.o_SampleValid = (r_Level != '0);
  assign bus.o_FifoLevel   = r_Level;

  // Sticky flags: a set event beats a same-cycle clear.
  logic set_ovr, set_clip, set_ferr;
  logic r_Ovr, r_Clip, r_Ferr;

  assign set_ovr  = frame_end & full & ~pop;
  assign set_clip = frame_end & (clip_hi | clip_lo);
  assign set_ferr = bus.i_SubsampleValid & at_max;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_Ovr  <= 1'b0;
      r_Clip <= 1'b0;
      r_Ferr <= 1'b0;
    end else begin
      r_Ovr  <= set_ovr  | (r_Ovr  & ~bus.i_ClearFlags);
      r_Clip <= set_clip | (r_Clip & ~bus.i_ClearFlags);
      r_Ferr <= set_ferr | (r_Ferr & ~bus.i_ClearFlags);
    end
  end

  assign bus.o_Overrun    = r_Ovr;
  assign bus.o_Clipped    = r_Clip;
  assign bus.o_FrameError = r_Ferr;
endmodule
